// File: rtl/mp_fifo_enq_sched_pkg.sv
// rtl/mp_fifo_enq_sched_pkg.sv - shared widths and lane select record for the enqueue scheduler
package mp_fifo_sched_pkg;

    // Wide enough for any requester index the scheduler is expected to see.
    localparam int IDX_W = 8;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } lane_sel_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wait_w(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mp_fifo_enq_sched_if.sv
// rtl/mp_fifo_enq_sched_if.sv - requester/FIFO-lane bundle: master drives requests, lane ready and flush; slave is the scheduler
interface mp_fifo_enq_sched_if #(
    parameter int REQ_NUM       = 6,
    parameter int ENQ_WIDTH     = 4,
    parameter int PAYLOAD_WIDTH = 2
);
    logic [REQ_NUM-1:0]                 req_vld_i;
    logic [REQ_NUM*PAYLOAD_WIDTH-1:0]   req_payload_i;
    logic [REQ_NUM-1:0]                 req_rdy_o;
    logic [ENQ_WIDTH-1:0]               lane_vld_o;
    logic [ENQ_WIDTH*PAYLOAD_WIDTH-1:0] lane_payload_o;
    logic [ENQ_WIDTH-1:0]               lane_rdy_i;
    logic                               flush_i;

    modport master (
        output req_vld_i, req_payload_i, lane_rdy_i, flush_i,
        input  req_rdy_o, lane_vld_o, lane_payload_o
    );

    modport slave (
        input  req_vld_i, req_payload_i, lane_rdy_i, flush_i,
        output req_rdy_o, lane_vld_o, lane_payload_o
    );

endinterface

// File: rtl/mp_fifo_enq_sched_circ_multi_pick.sv
// rtl/mp_fifo_enq_sched_circ_multi_pick.sv - first N set bits of a mask in circular order from a start pointer
module circ_multi_pick
    import mp_fifo_sched_pkg::*;
#(
    parameter int N_REQ  = 6,
    parameter int N_PICK = 4,
    localparam int PTR_W = ptr_w(N_REQ),
    localparam int CNT_W = $clog2(N_PICK + 1)
) (
    input  logic [N_REQ-1:0] mask_i,
    input  logic [PTR_W-1:0] start_i,
    output lane_sel_t        sel_o [N_PICK],
    output logic [CNT_W-1:0] cnt_o
);

    logic [2*N_REQ-1:0] dbl_mask;
    int                 rank;
    int                 idx;

    // Rotating a doubled copy puts circular position i at bit i, so the
    // scan below only ever uses constant bit selects.
    always_comb begin
        dbl_mask = {mask_i, mask_i} >> start_i;
        rank     = 0;
        idx      = 0;
        for (int k = 0; k < N_PICK; k++) begin
            sel_o[k] = '0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(start_i) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (dbl_mask[i]) begin
                for (int k = 0; k < N_PICK; k++) begin
                    if (rank == k) begin
                        sel_o[k].vld = 1'b1;
                        sel_o[k].idx = IDX_W'(idx);
                    end
                end
                if (rank < N_PICK) begin
                    rank = rank + 1;
                end
            end
        end
        cnt_o = CNT_W'(rank);
    end

endmodule

// File: rtl/mp_fifo_enq_sched.sv
// rtl/mp_fifo_enq_sched.sv - round-robin aging scheduler onto multi-port FIFO enqueue lanes; perf counters under MP_FIFO_ENQ_SCHED_PERF_EN
module mp_fifo_enq_sched
    import mp_fifo_sched_pkg::*;
#(
    parameter int REQ_NUM       = 6,
    parameter int ENQ_WIDTH     = 4,
    parameter int PAYLOAD_WIDTH = 2,
    parameter int MAX_WAIT      = 7
) (
    input  logic                clk,
    input  logic                rst,
    mp_fifo_enq_sched_if.slave  bus
`ifdef MP_FIFO_ENQ_SCHED_PERF_EN
    ,
    output logic [31:0]         perf_stall_cnt_o,
    output logic [31:0]         perf_urgent_cnt_o
`endif
);

    localparam int PTR_W  = ptr_w(REQ_NUM);
    localparam int WAIT_W = wait_w(MAX_WAIT);
    localparam int CNT_W  = $clog2(ENQ_WIDTH + 1);

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WAIT_W-1:0] wait_cnt_q [REQ_NUM];
    logic [WAIT_W-1:0] wait_cnt_d [REQ_NUM];

    logic [REQ_NUM-1:0] urgent;
    logic [REQ_NUM-1:0] urg_mask;
    logic [REQ_NUM-1:0] non_mask;
    logic [REQ_NUM-1:0] fire;

    lane_sel_t          u_sel    [ENQ_WIDTH];
    lane_sel_t          n_sel    [ENQ_WIDTH];
    lane_sel_t          lane_sel [ENQ_WIDTH];
    logic [CNT_W-1:0]   u_cnt;
    logic [CNT_W-1:0]   n_cnt;

    logic               any_fire;
    logic [IDX_W-1:0]   last_idx;
    int                 nxt_ptr;

    always_comb begin
        for (int r = 0; r < REQ_NUM; r++) begin
            urgent[r] = (wait_cnt_q[r] == WAIT_W'(MAX_WAIT));
        end
        urg_mask = bus.req_vld_i & urgent;
        non_mask = bus.req_vld_i & ~urgent;
    end

    circ_multi_pick #(.N_REQ(REQ_NUM), .N_PICK(ENQ_WIDTH)) u_pick_urgent (
        .mask_i  (urg_mask),
        .start_i (rr_ptr_q),
        .sel_o   (u_sel),
        .cnt_o   (u_cnt)
    );

    circ_multi_pick #(.N_REQ(REQ_NUM), .N_PICK(ENQ_WIDTH)) u_pick_normal (
        .mask_i  (non_mask),
        .start_i (rr_ptr_q),
        .sel_o   (n_sel),
        .cnt_o   (n_cnt)
    );

    // Urgent picks occupy lanes 0..u_cnt-1; normal picks fill the rest in order.
    always_comb begin
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            lane_sel[k] = '0;
            if (k < int'(u_cnt)) begin
                lane_sel[k] = u_sel[k];
            end else begin
                for (int j = 0; j < ENQ_WIDTH; j++) begin
                    if (j + int'(u_cnt) == k) begin
                        lane_sel[k] = n_sel[j];
                    end
                end
            end
        end
    end

    // Lanes are offered regardless of lane_rdy_i; ready only gates the grant.
    // The highest fired lane is the last fired requester in candidate order.
    always_comb begin
        bus.lane_vld_o     = '0;
        bus.lane_payload_o = '0;
        bus.req_rdy_o      = '0;
        any_fire           = 1'b0;
        last_idx           = '0;
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            if (lane_sel[k].vld && !bus.flush_i) begin
                bus.lane_vld_o[k] = 1'b1;
                for (int r = 0; r < REQ_NUM; r++) begin
                    if (lane_sel[k].idx == IDX_W'(r)) begin
                        bus.lane_payload_o[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] =
                            bus.req_payload_i[r*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
                        bus.req_rdy_o[r] = bus.lane_rdy_i[k];
                    end
                end
                if (bus.lane_rdy_i[k]) begin
                    any_fire = 1'b1;
                    last_idx = lane_sel[k].idx;
                end
            end
        end
        fire = bus.req_vld_i & bus.req_rdy_o;
    end

    always_comb begin
        nxt_ptr = int'(last_idx) + 1;
        if (nxt_ptr >= REQ_NUM) begin
            nxt_ptr = 0;
        end
        rr_ptr_d = rr_ptr_q;
        if (bus.flush_i) begin
            rr_ptr_d = '0;
        end else if (any_fire) begin
            rr_ptr_d = PTR_W'(nxt_ptr);
        end
        for (int r = 0; r < REQ_NUM; r++) begin
            wait_cnt_d[r] = '0;
            if (!bus.flush_i && bus.req_vld_i[r] && !fire[r]) begin
                wait_cnt_d[r] = urgent[r] ? wait_cnt_q[r] : wait_cnt_q[r] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            for (int r = 0; r < REQ_NUM; r++) begin
                wait_cnt_q[r] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int r = 0; r < REQ_NUM; r++) begin
                wait_cnt_q[r] <= wait_cnt_d[r];
            end
        end
    end

`ifdef MP_FIFO_ENQ_SCHED_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_urgent_q, perf_urgent_d;

    // Flush cycles with pending requests count as stalls; flush never clears these.
    always_comb begin
        perf_stall_d  = perf_stall_q;
        perf_urgent_d = perf_urgent_q;
        if ((|bus.req_vld_i) && !any_fire) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        for (int r = 0; r < REQ_NUM; r++) begin
            if (fire[r] && urgent[r]) begin
                perf_urgent_d = perf_urgent_d + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q  <= '0;
            perf_urgent_q <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_urgent_q <= perf_urgent_d;
        end
    end

    assign perf_stall_cnt_o  = perf_stall_q;
    assign perf_urgent_cnt_o = perf_urgent_q;
`endif

endmodule

// File: tb/tb_mp_fifo_enq_sched.sv
// tb/tb_mp_fifo_enq_sched.sv - directed self-checking bench for mp_fifo_enq_sched
module tb_mp_fifo_enq_sched;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mp_fifo_enq_sched_if #(.REQ_NUM(6), .ENQ_WIDTH(4), .PAYLOAD_WIDTH(2)) bus_if ();

`ifdef MP_FIFO_ENQ_SCHED_PERF_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_urgent;
`endif

    mp_fifo_enq_sched #(
        .REQ_NUM(6), .ENQ_WIDTH(4), .PAYLOAD_WIDTH(2), .MAX_WAIT(7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
`ifdef MP_FIFO_ENQ_SCHED_PERF_EN
        ,
        .perf_stall_cnt_o  (perf_stall),
        .perf_urgent_cnt_o (perf_urgent)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester r carries payload (r+1)%4: p0..p5 = 1,2,3,0,1,2.
    localparam logic [11:0] PAYLOADS = 12'h939;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus_if.req_vld_i     = '0;
        bus_if.req_payload_i = PAYLOADS;
        bus_if.lane_rdy_i    = '0;
        bus_if.flush_i       = 1'b0;
        tick(); tick();
        total++; if (bus_if.lane_vld_o !== 4'h0) begin bad++; $display("FAIL reset_lane_vld got=%h exp=0", bus_if.lane_vld_o); end
        total++; if (bus_if.req_rdy_o !== 6'h00) begin bad++; $display("FAIL reset_req_rdy got=%h exp=0", bus_if.req_rdy_o); end
        total++; if (dut.rr_ptr_q !== 3'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", dut.rr_ptr_q); end
        for (int r = 0; r < 6; r++) begin
            total++; if (dut.wait_cnt_q[r] !== 3'd0) begin bad++; $display("FAIL reset_wait%0d got=%0d exp=0", r, dut.wait_cnt_q[r]); end
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_all_valid();
        bus_if.req_vld_i  = 6'h3f;
        bus_if.lane_rdy_i = 4'hf;
        #1;
        total++; if (bus_if.lane_vld_o !== 4'hf) begin bad++; $display("FAIL all1_lane_vld got=%h exp=f", bus_if.lane_vld_o); end
        total++; if (bus_if.req_rdy_o !== 6'h0f) begin bad++; $display("FAIL all1_req_rdy got=%h exp=0f", bus_if.req_rdy_o); end
        total++; if (bus_if.lane_payload_o !== 8'h39) begin bad++; $display("FAIL all1_payload got=%h exp=39", bus_if.lane_payload_o); end
        tick();
        total++; if (dut.rr_ptr_q !== 3'd4) begin bad++; $display("FAIL all1_ptr got=%0d exp=4", dut.rr_ptr_q); end
        #1;
        total++; if (bus_if.req_rdy_o !== 6'h33) begin bad++; $display("FAIL all2_req_rdy got=%h exp=33", bus_if.req_rdy_o); end
        total++; if (bus_if.lane_payload_o !== 8'h99) begin bad++; $display("FAIL all2_payload got=%h exp=99", bus_if.lane_payload_o); end
        tick();
        total++; if (dut.rr_ptr_q !== 3'd2) begin bad++; $display("FAIL all2_ptr got=%0d exp=2", dut.rr_ptr_q); end
        total++; if (dut.wait_cnt_q[2] !== 3'd1) begin bad++; $display("FAIL all2_wait2 got=%0d exp=1", dut.wait_cnt_q[2]); end
        // Lone req 2 fires and moves the pointer to 3.
        bus_if.req_vld_i = 6'b000100;
        tick();
        total++; if (dut.rr_ptr_q !== 3'd3) begin bad++; $display("FAIL lone2_ptr got=%0d exp=3", dut.rr_ptr_q); end
    endtask

    task automatic test_sparse_wrap();
        bus_if.req_vld_i  = 6'b100010;
        bus_if.lane_rdy_i = 4'hf;
        #1;
        total++; if (bus_if.lane_vld_o !== 4'b0011) begin bad++; $display("FAIL sparse_lane_vld got=%b exp=0011", bus_if.lane_vld_o); end
        total++; if (bus_if.req_rdy_o !== 6'b100010) begin bad++; $display("FAIL sparse_req_rdy got=%b exp=100010", bus_if.req_rdy_o); end
        total++; if (bus_if.lane_payload_o !== 8'h0a) begin bad++; $display("FAIL sparse_payload got=%h exp=0a", bus_if.lane_payload_o); end
        tick();
        total++; if (dut.rr_ptr_q !== 3'd2) begin bad++; $display("FAIL sparse_ptr got=%0d exp=2", dut.rr_ptr_q); end
    endtask

    task automatic test_aging();
        bus_if.req_vld_i  = 6'b000100;
        bus_if.lane_rdy_i = 4'hf;
        tick();
        total++; if (dut.rr_ptr_q !== 3'd3) begin bad++; $display("FAIL age_setup_ptr got=%0d exp=3", dut.rr_ptr_q); end
        bus_if.lane_rdy_i = 4'h0;
        #1;
        total++; if (bus_if.lane_vld_o !== 4'b0001) begin bad++; $display("FAIL full_lane_vld got=%b exp=0001", bus_if.lane_vld_o); end
        total++; if (bus_if.req_rdy_o !== 6'h00) begin bad++; $display("FAIL full_req_rdy got=%h exp=00", bus_if.req_rdy_o); end
        for (int c = 0; c < 7; c++) tick();
        total++; if (dut.wait_cnt_q[2] !== 3'd7) begin bad++; $display("FAIL age_wait2 got=%0d exp=7", dut.wait_cnt_q[2]); end
        total++; if (dut.rr_ptr_q !== 3'd3) begin bad++; $display("FAIL full_ptr_hold got=%0d exp=3", dut.rr_ptr_q); end
        tick();
        total++; if (dut.wait_cnt_q[2] !== 3'd7) begin bad++; $display("FAIL age_saturate got=%0d exp=7", dut.wait_cnt_q[2]); end
        bus_if.req_vld_i  = 6'h3f;
        bus_if.lane_rdy_i = 4'hf;
        #1;
        total++; if (bus_if.req_rdy_o !== 6'b111100) begin bad++; $display("FAIL urgent_req_rdy got=%b exp=111100", bus_if.req_rdy_o); end
        total++; if (bus_if.lane_payload_o !== 8'h93) begin bad++; $display("FAIL urgent_payload got=%h exp=93", bus_if.lane_payload_o); end
        tick();
        total++; if (dut.rr_ptr_q !== 3'd0) begin bad++; $display("FAIL urgent_ptr got=%0d exp=0", dut.rr_ptr_q); end
        total++; if (dut.wait_cnt_q[2] !== 3'd0) begin bad++; $display("FAIL urgent_wait2 got=%0d exp=0", dut.wait_cnt_q[2]); end
        total++; if (dut.wait_cnt_q[1] !== 3'd1) begin bad++; $display("FAIL urgent_wait1 got=%0d exp=1", dut.wait_cnt_q[1]); end
    endtask

    task automatic test_flush();
        bus_if.req_vld_i  = 6'h3f;
        bus_if.lane_rdy_i = 4'b0001;
        #1;
        total++; if (bus_if.req_rdy_o !== 6'b000001) begin bad++; $display("FAIL preflush_req_rdy got=%b exp=000001", bus_if.req_rdy_o); end
        tick();
        total++; if (dut.rr_ptr_q !== 3'd1) begin bad++; $display("FAIL preflush_ptr got=%0d exp=1", dut.rr_ptr_q); end
        bus_if.flush_i    = 1'b1;
        bus_if.lane_rdy_i = 4'hf;
        #1;
        total++; if (bus_if.lane_vld_o !== 4'h0) begin bad++; $display("FAIL flush_lane_vld got=%h exp=0", bus_if.lane_vld_o); end
        total++; if (bus_if.req_rdy_o !== 6'h00) begin bad++; $display("FAIL flush_req_rdy got=%h exp=00", bus_if.req_rdy_o); end
        tick();
        bus_if.flush_i   = 1'b0;
        bus_if.req_vld_i = 6'h00;
        total++; if (dut.rr_ptr_q !== 3'd0) begin bad++; $display("FAIL flush_ptr got=%0d exp=0", dut.rr_ptr_q); end
        for (int r = 0; r < 6; r++) begin
            total++; if (dut.wait_cnt_q[r] !== 3'd0) begin bad++; $display("FAIL flush_wait%0d got=%0d exp=0", r, dut.wait_cnt_q[r]); end
        end
    endtask

    task automatic test_partial_rdy();
        bus_if.req_vld_i  = 6'b001111;
        bus_if.lane_rdy_i = 4'b0011;
        #1;
        total++; if (bus_if.lane_vld_o !== 4'hf) begin bad++; $display("FAIL partial_lane_vld got=%h exp=f", bus_if.lane_vld_o); end
        total++; if (bus_if.req_rdy_o !== 6'b000011) begin bad++; $display("FAIL partial_req_rdy got=%b exp=000011", bus_if.req_rdy_o); end
        tick();
        total++; if (dut.rr_ptr_q !== 3'd2) begin bad++; $display("FAIL partial_ptr got=%0d exp=2", dut.rr_ptr_q); end
        total++; if (dut.wait_cnt_q[2] !== 3'd1) begin bad++; $display("FAIL partial_wait2 got=%0d exp=1", dut.wait_cnt_q[2]); end
        total++; if (dut.wait_cnt_q[3] !== 3'd1) begin bad++; $display("FAIL partial_wait3 got=%0d exp=1", dut.wait_cnt_q[3]); end
        total++; if (dut.wait_cnt_q[0] !== 3'd0) begin bad++; $display("FAIL partial_wait0 got=%0d exp=0", dut.wait_cnt_q[0]); end
    endtask

    task automatic test_async_reset();
        bus_if.lane_rdy_i = 4'h0;
        tick();
        total++; if (dut.wait_cnt_q[2] !== 3'd2) begin bad++; $display("FAIL prerst_wait2 got=%0d exp=2", dut.wait_cnt_q[2]); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (dut.rr_ptr_q !== 3'd0) begin bad++; $display("FAIL arst_ptr got=%0d exp=0", dut.rr_ptr_q); end
        total++; if (dut.wait_cnt_q[2] !== 3'd0) begin bad++; $display("FAIL arst_wait2 got=%0d exp=0", dut.wait_cnt_q[2]); end
        bus_if.req_vld_i = 6'h00;
        tick();
        rst = 1'b1;
        tick();
    endtask

`ifdef MP_FIFO_ENQ_SCHED_PERF_EN
    task automatic test_perf();
        total++; if (perf_stall !== 32'd0) begin bad++; $display("FAIL perf_stall_reset got=%0d exp=0", perf_stall); end
        bus_if.req_vld_i  = 6'b100001;
        bus_if.lane_rdy_i = 4'b0001;
        tick();
        bus_if.req_vld_i  = 6'b100010;
        tick();
        bus_if.req_vld_i  = 6'b100000;
        bus_if.lane_rdy_i = 4'h0;
        for (int c = 0; c < 5; c++) tick();
        total++; if (dut.wait_cnt_q[5] !== 3'd7) begin bad++; $display("FAIL perf_wait5 got=%0d exp=7", dut.wait_cnt_q[5]); end
        bus_if.lane_rdy_i = 4'b0001;
        #1;
        total++; if (bus_if.req_rdy_o !== 6'b100000) begin bad++; $display("FAIL perf_req_rdy got=%b exp=100000", bus_if.req_rdy_o); end
        tick();
        bus_if.req_vld_i = 6'h00;
        total++; if (perf_stall !== 32'd5) begin bad++; $display("FAIL perf_stall got=%0d exp=5", perf_stall); end
        total++; if (perf_urgent !== 32'd1) begin bad++; $display("FAIL perf_urgent got=%0d exp=1", perf_urgent); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_all_valid();
        test_sparse_wrap();
        test_aging();
        test_flush();
        test_partial_rdy();
        test_async_reset();
`ifdef MP_FIFO_ENQ_SCHED_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
